// File: rtl/cmos_capture_crop.sv
// CMOS sensor capture front end: frames the byte stream with vsync/href, packs
// BPP bytes per pixel, applies a per-frame crop window and frame decimation.
module cmos_capture_crop #(
    parameter int DATA_W = 8,
    parameter int BPP    = 2,
    parameter int SWAP   = 0,
    parameter int VS_POL = 1,
    parameter int CW     = 12,
    parameter int FCW    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vsync_i,
    input  logic                  href_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [CW-1:0]         win_x0,
    input  logic [CW-1:0]         win_y0,
    input  logic [CW-1:0]         win_w,
    input  logic [CW-1:0]         win_h,
    input  logic [FCW-1:0]        skip_n,
    output logic [DATA_W*BPP-1:0] pix_data,
    output logic                  pix_valid,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  frame_done,
    output logic [FCW-1:0]        frame_cnt
);

    localparam int             PW        = DATA_W * BPP;
    localparam int             BCW       = (BPP > 1) ? $clog2(BPP) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPP - 1);
    localparam logic           VS_LVL    = 1'(VS_POL);

    typedef enum logic [1:0] {
        S_WAIT_VS,
        S_WAIT_END,
        S_ACTIVE
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   x0_reg, y0_reg, w_reg, h_reg;
    logic [FCW-1:0]  dec_cnt_reg;
    logic            en_reg;
    logic [CW-1:0]   x_reg, y_reg;
    logic [BCW-1:0]  byte_cnt_reg;
    logic            href_d_reg;
    logic            line_seen_reg;
    logic [DATA_W-1:0] byte_buf [0:BPP-1];

    logic            vs_act;
    logic            cap;
    logic            last_byte;
    logic            line_end;
    logic [CW:0]     x_end, y_end;
    logic            in_win;
    logic            eol_hit;
    logic [PW-1:0]   word;

    assign vs_act    = (vsync_i == VS_LVL);
    assign cap       = (state_reg == S_ACTIVE) && href_i;
    assign last_byte = cap && (byte_cnt_reg == LAST_BYTE);
    assign line_end  = (state_reg == S_ACTIVE) && href_d_reg && !href_i;

    // One extra bit on the window ends keeps x0+w from wrapping.
    assign x_end   = {1'b0, x0_reg} + {1'b0, w_reg};
    assign y_end   = {1'b0, y0_reg} + {1'b0, h_reg};
    assign in_win  = en_reg
                     && (x_reg >= x0_reg) && ({1'b0, x_reg} < x_end)
                     && (y_reg >= y0_reg) && ({1'b0, y_reg} < y_end);
    assign eol_hit = (({1'b0, x_reg} + 1'b1) == x_end);

    // Earlier bytes come from the buffer, the final byte straight off the bus.
    for (genvar gi = 0; gi < BPP; gi++) begin : g_pack
        localparam int POS = (SWAP != 0) ? gi : (BPP - 1 - gi);
        if (gi == BPP - 1) begin : g_last
            assign word[POS*DATA_W +: DATA_W] = data_i;
        end else begin : g_buf
            assign word[POS*DATA_W +: DATA_W] = byte_buf[gi];
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            byte_buf[byte_cnt_reg] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_WAIT_VS;
            x0_reg        <= '0;
            y0_reg        <= '0;
            w_reg         <= '0;
            h_reg         <= '0;
            dec_cnt_reg   <= '0;
            en_reg        <= 1'b0;
            x_reg         <= '0;
            y_reg         <= '0;
            byte_cnt_reg  <= '0;
            href_d_reg    <= 1'b0;
            line_seen_reg <= 1'b0;
            pix_data      <= '0;
            pix_valid     <= 1'b0;
            pix_sof       <= 1'b0;
            pix_eol       <= 1'b0;
            frame_done    <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            frame_done <= 1'b0;
            href_d_reg <= href_i;

            case (state_reg)
                S_WAIT_VS: begin
                    if (vs_act) begin
                        state_reg <= S_WAIT_END;
                    end
                end
                S_WAIT_END: begin
                    if (!vs_act) begin
                        state_reg     <= S_ACTIVE;
                        x0_reg        <= win_x0;
                        y0_reg        <= win_y0;
                        w_reg         <= win_w;
                        h_reg         <= win_h;
                        x_reg         <= '0;
                        y_reg         <= '0;
                        byte_cnt_reg  <= '0;
                        line_seen_reg <= 1'b0;
                        en_reg        <= (dec_cnt_reg == '0);
                        // skip_n is only consulted here, so it is frame-stable.
                        dec_cnt_reg   <= (dec_cnt_reg >= skip_n) ? '0 : dec_cnt_reg + 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (vs_act) begin
                        state_reg <= S_WAIT_END;
                        if (en_reg) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: state_reg <= S_WAIT_VS;
            endcase

            if (cap) begin
                line_seen_reg <= 1'b1;
                if (last_byte) begin
                    byte_cnt_reg <= '0;
                    if (x_reg != '1) begin
                        x_reg <= x_reg + 1'b1;
                    end
                    if (in_win) begin
                        pix_valid <= 1'b1;
                        pix_data  <= word;
                        pix_sof   <= (x_reg == x0_reg) && (y_reg == y0_reg);
                        pix_eol   <= eol_hit;
                    end
                end else begin
                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                end
            end else if (line_end) begin
                x_reg         <= '0;
                byte_cnt_reg  <= '0;
                line_seen_reg <= 1'b0;
                if (line_seen_reg && (y_reg != '1)) begin
                    y_reg <= y_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmos_capture_crop.sv
// Randomized bench for cmos_capture_crop: frames are built as byte arrays and the
// expected pixel list is derived from window arithmetic over those arrays.
module tb_cmos_capture_crop;

    localparam int DATA_W = 8;
    localparam int BPP    = 2;
    localparam int CW     = 12;
    localparam int FCW    = 8;
    localparam int PW     = DATA_W * BPP;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              vsync_i = 1'b0;
    logic              href_i = 1'b0;
    logic [DATA_W-1:0] data_i = '0;
    logic [CW-1:0]     win_x0 = '0, win_y0 = '0, win_w = '0, win_h = '0;
    logic [FCW-1:0]    skip_n = '0;
    logic [PW-1:0]     pix_data;
    logic              pix_valid, pix_sof, pix_eol, frame_done;
    logic [FCW-1:0]    frame_cnt;

    always #5 clk = ~clk;

    cmos_capture_crop #(
        .DATA_W(DATA_W), .BPP(BPP), .SWAP(0), .VS_POL(1), .CW(CW), .FCW(FCW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync_i), .href_i(href_i), .data_i(data_i),
        .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h), .skip_n(skip_n),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    typedef struct packed {
        logic [PW-1:0] data;
        logic          sof;
        logic          eol;
    } pix_t;

    pix_t        got_q[$];
    pix_t        exp_q[$];
    int          fd_count = 0;
    int          tests = 0;
    int          fails = 0;
    int          exp_fcnt = 0;
    logic [7:0]  fr_b [0:7][0:31];
    int          fr_len [0:7];
    int          fr_n = 0;

    always @(negedge clk) begin
        pix_t p;
        if (pix_valid) begin
            p.data = pix_data;
            p.sof  = pix_sof;
            p.eol  = pix_eol;
            got_q.push_back(p);
        end else if (pix_sof || pix_eol || (pix_data != '0)) begin
            fails++;
            $display("FAIL idle_outputs: sof=%b eol=%b data=%h, want all zero", pix_sof, pix_eol, pix_data);
        end
        if (frame_done) fd_count++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected pixels: every complete BPP-byte group of a line is a pixel at
    // (group index, count of earlier non-empty lines); keep those in the window.
    task automatic model_frame(input bit en, input int x0, input int y0, input int w, input int h);
        int   y;
        pix_t p;
        exp_q.delete();
        y = 0;
        for (int l = 0; l < fr_n; l++) begin
            if (fr_len[l] > 0) begin
                for (int j = 0; j < fr_len[l] / BPP; j++) begin
                    if (en && j >= x0 && j < x0 + w && y >= y0 && y < y0 + h) begin
                        p.data = '0;
                        for (int k = 0; k < BPP; k++)
                            p.data = p.data | (PW'(fr_b[l][j*BPP+k]) << ((BPP - 1 - k) * 8));
                        p.sof = (j == x0) && (y == y0);
                        p.eol = (j == x0 + w - 1);
                        exp_q.push_back(p);
                    end
                end
                y++;
            end
        end
    endtask

    task automatic fill_random(input int nl, input int maxlen);
        fr_n = nl;
        for (int l = 0; l < nl; l++) begin
            fr_len[l] = $urandom_range(maxlen, 1);
            for (int b = 0; b < 32; b++) fr_b[l][b] = 8'($urandom);
        end
    endtask

    task automatic fill_seq(input int nl, input int len);
        fr_n = nl;
        for (int l = 0; l < nl; l++) begin
            fr_len[l] = len;
            for (int b = 0; b < 32; b++) fr_b[l][b] = 8'(l * len + b);
        end
    endtask

    // Drives one frame; vsync is left asserted so the next frame just continues it.
    task automatic drive_frame(input int chg_line, input logic [CW-1:0] nx0, input logic [CW-1:0] ny0,
                               input logic [CW-1:0] nw, input logic [CW-1:0] nh,
                               input bit last_vs, input bit en_exp);
        model_frame(en_exp, int'(win_x0), int'(win_y0), int'(win_w), int'(win_h));
        got_q.delete();
        fd_count = 0;
        repeat (3) begin @(negedge clk); vsync_i = 1'b1; end
        @(negedge clk); vsync_i = 1'b0;
        repeat (2) @(negedge clk);
        for (int l = 0; l < fr_n; l++) begin
            if (l == chg_line) begin
                win_x0 = nx0; win_y0 = ny0; win_w = nw; win_h = nh;
            end
            for (int b = 0; b < fr_len[l]; b++) begin
                @(negedge clk);
                href_i = 1'b1;
                data_i = fr_b[l][b];
                if (last_vs && l == fr_n - 1 && b == fr_len[l] - 1) vsync_i = 1'b1;
            end
            @(negedge clk); href_i = 1'b0; data_i = '0;
            repeat (2) @(negedge clk);
        end
        vsync_i = 1'b1;
        repeat (4) @(negedge clk);
        if (en_exp) exp_fcnt++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; vsync_i = 1'b0; href_i = 1'b0; data_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_fcnt = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if ({pix_valid, pix_sof, pix_eol, frame_done} !== 4'b0 || pix_data !== '0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b sof=%b eol=%b done=%b data=%h, want 0",
                     pix_valid, pix_sof, pix_eol, frame_done, pix_data);
        end
        tests++;
        if (frame_cnt !== '0) begin
            fails++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
        end
    endtask

    task automatic test_basic();
        logic [PW-1:0] want;
        win_x0 = 0; win_y0 = 0; win_w = 4; win_h = 4; skip_n = 0;
        fill_random(4, 8);
        for (int l = 0; l < 4; l++) fr_len[l] = 8;
        drive_frame(-1, 0, 0, 0, 0, 1'b0, 1'b1);
        tests++;
        if (got_q.size() !== 16) begin
            fails++; $display("FAIL basic_count: got %0d want 16", got_q.size());
        end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            want = {fr_b[i/4][2*(i%4)], fr_b[i/4][2*(i%4)+1]};
            tests++;
            if (got_q[i].data !== want || got_q[i].sof !== (i == 0) || got_q[i].eol !== (i % 4 == 3)) begin
                fails++;
                $display("FAIL basic_pix%0d: got data=%h sof=%b eol=%b want data=%h sof=%b eol=%b",
                         i, got_q[i].data, got_q[i].sof, got_q[i].eol, want, (i == 0), (i % 4 == 3));
            end
        end
        tests++;
        if (fd_count !== 1) begin fails++; $display("FAIL basic_frame_done: got %0d want 1", fd_count); end
        tests++;
        if (frame_cnt !== 8'd1) begin fails++; $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_crop();
        win_x0 = 1; win_y0 = 2; win_w = 2; win_h = 1;
        fill_seq(4, 8);
        drive_frame(-1, 0, 0, 0, 0, 1'b0, 1'b1);
        tests++;
        if (got_q.size() !== 2) begin
            fails++; $display("FAIL crop_count: got %0d want 2", got_q.size());
        end else begin
            tests++;
            if (got_q[0] !== {16'h1213, 1'b1, 1'b0} || got_q[1] !== {16'h1415, 1'b0, 1'b1}) begin
                fails++;
                $display("FAIL crop_pixels: got %h/%b%b %h/%b%b want 1213/10 1415/01",
                         got_q[0].data, got_q[0].sof, got_q[0].eol, got_q[1].data, got_q[1].sof, got_q[1].eol);
            end
        end
        tests++;
        if (frame_cnt !== 8'(exp_fcnt)) begin
            fails++; $display("FAIL crop_frame_cnt: got %0d want %0d", frame_cnt, exp_fcnt);
        end
    endtask

    task automatic test_partial_line();
        win_x0 = 0; win_y0 = 0; win_w = 16; win_h = 16;
        fill_random(2, 8);
        fr_len[0] = 3; fr_len[1] = 4;
        drive_frame(-1, 0, 0, 0, 0, 1'b0, 1'b1);
        tests++;
        if (got_q.size() !== 3) begin
            fails++; $display("FAIL partial_count: got %0d want 3", got_q.size());
        end else begin
            tests++;
            if (got_q[0] !== {fr_b[0][0], fr_b[0][1], 1'b1, 1'b0} ||
                got_q[1] !== {fr_b[1][0], fr_b[1][1], 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL partial_restart: got %h/%b %h/%b want %h%h/1 %h%h/0",
                         got_q[0].data, got_q[0].sof, got_q[1].data, got_q[1].sof,
                         fr_b[0][0], fr_b[0][1], fr_b[1][0], fr_b[1][1]);
            end
        end
    endtask

    task automatic test_random_frames();
        bit lv;
        for (int f = 0; f < 8; f++) begin
            win_x0 = CW'($urandom_range(6, 0));
            win_y0 = CW'($urandom_range(4, 0));
            win_w  = CW'($urandom_range(12, 0));
            win_h  = CW'($urandom_range(6, 0));
            lv     = 1'($urandom_range(1, 0));
            fill_random($urandom_range(6, 1), 20);
            drive_frame(-1, 0, 0, 0, 0, lv, 1'b1);
            tests++;
            if (got_q.size() !== exp_q.size()) begin
                fails++;
                $display("FAIL random%0d_count: got %0d want %0d (win %0d,%0d,%0d,%0d)",
                         f, got_q.size(), exp_q.size(), win_x0, win_y0, win_w, win_h);
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                tests++;
                if (got_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL random%0d_pix%0d: got %h/%b%b want %h/%b%b", f, i,
                             got_q[i].data, got_q[i].sof, got_q[i].eol, exp_q[i].data, exp_q[i].sof, exp_q[i].eol);
                end
            end
            tests++;
            if (fd_count !== 1 || frame_cnt !== 8'(exp_fcnt)) begin
                fails++;
                $display("FAIL random%0d_frame: done=%0d cnt=%0d want 1/%0d", f, fd_count, frame_cnt, exp_fcnt);
            end
        end
    endtask

    task automatic test_skip();
        int total_fd, start_cnt;
        bit en;
        skip_n = 2; win_x0 = 0; win_y0 = 0; win_w = 8; win_h = 8;
        total_fd = 0;
        start_cnt = exp_fcnt;
        for (int f = 0; f < 6; f++) begin
            en = (f % 3 == 0);
            fill_random(3, 10);
            drive_frame(-1, 0, 0, 0, 0, 1'b0, en);
            total_fd += fd_count;
            tests++;
            if (got_q.size() !== exp_q.size() || (got_q.size() > 0) !== en) begin
                fails++;
                $display("FAIL skip_frame%0d: got %0d pixels want %0d", f, got_q.size(), exp_q.size());
            end
        end
        tests++;
        if (total_fd !== 2) begin fails++; $display("FAIL skip_frame_done: got %0d want 2", total_fd); end
        tests++;
        if (frame_cnt !== 8'(start_cnt + 2)) begin
            fails++; $display("FAIL skip_frame_cnt: got %0d want %0d", frame_cnt, start_cnt + 2);
        end
        skip_n = 0;
    endtask

    task automatic test_window_change();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin win_x0 = 0; win_y0 = 0; win_w = 4; win_h = 4; end
            fill_random(4, 8);
            for (int l = 0; l < 4; l++) fr_len[l] = 8;
            drive_frame(pass == 0 ? 1 : -1, 1, 1, 2, 2, 1'b0, 1'b1);
            tests++;
            if (got_q.size() !== (pass == 0 ? 16 : 4) || got_q.size() !== exp_q.size()) begin
                fails++;
                $display("FAIL winchg%0d_count: got %0d want %0d", pass, got_q.size(), pass == 0 ? 16 : 4);
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                tests++;
                if (got_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL winchg%0d_pix%0d: got %h/%b%b want %h/%b%b", pass, i,
                             got_q[i].data, got_q[i].sof, got_q[i].eol, exp_q[i].data, exp_q[i].sof, exp_q[i].eol);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        win_x0 = 0; win_y0 = 0; win_w = 16; win_h = 16;
        repeat (3) begin @(negedge clk); vsync_i = 1'b1; end
        @(negedge clk); vsync_i = 1'b0;
        repeat (2) @(negedge clk);
        href_i = 1'b1; data_i = 8'hA1;
        @(negedge clk); data_i = 8'hA2;
        @(posedge clk); #2;
        tests++;
        if (pix_valid !== 1'b1 || pix_data !== 16'hA1A2) begin
            fails++; $display("FAIL rstmid_pre: valid=%b data=%h want 1/a1a2", pix_valid, pix_data);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({pix_valid, pix_sof, pix_eol, frame_done} !== 4'b0 || pix_data !== '0 || frame_cnt !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs: valid=%b sof=%b data=%h cnt=%0d want 0", pix_valid, pix_sof, pix_data, frame_cnt);
        end
        exp_fcnt = 0;
        got_q.delete();
        fd_count = 0;
        repeat (2) begin @(negedge clk); data_i = 8'($urandom); end
        rst_n = 1'b1;
        for (int b = 0; b < 6; b++) begin @(negedge clk); data_i = 8'($urandom); end
        @(negedge clk); href_i = 1'b0; data_i = '0;
        repeat (2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin @(negedge clk); href_i = 1'b1; data_i = 8'($urandom); end
        @(negedge clk); href_i = 1'b0; data_i = '0;
        repeat (2) @(negedge clk);
        vsync_i = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if (got_q.size() !== 0 || fd_count !== 0) begin
            fails++; $display("FAIL rstmid_partial_frame: pixels=%0d done=%0d want 0/0", got_q.size(), fd_count);
        end
        fill_random(3, 12);
        drive_frame(-1, 0, 0, 0, 0, 1'b0, 1'b1);
        tests++;
        if (got_q.size() !== exp_q.size() || got_q.size() == 0) begin
            fails++; $display("FAIL rstmid_next_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL rstmid_next_pix%0d: got %h/%b%b want %h/%b%b", i,
                         got_q[i].data, got_q[i].sof, got_q[i].eol, exp_q[i].data, exp_q[i].sof, exp_q[i].eol);
            end
        end
        tests++;
        if (frame_cnt !== 8'd1 || fd_count !== 1) begin
            fails++; $display("FAIL rstmid_next_frame: cnt=%0d done=%0d want 1/1", frame_cnt, fd_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crop();
        test_partial_line();
        test_random_frames();
        test_skip();
        test_window_change();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
